// File: rtl/warp_scheduler.sv
// warp_scheduler: per-core phase sequencer.
//
// Steps one core through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE
// for every instruction. WAIT holds while any live, unmasked lane still has
// an outstanding LSU transaction. RET ends the block in DONE. A watchdog
// aborts a WAIT that runs too long, and a retired-instruction counter is kept.
//
// Ports:
//   clk            core clock, rising edge
//   reset          asynchronous active-high reset
//   start          block dispatched (looked at in IDLE only)
//   thread_count   number of live lanes; lanes at or above it are ignored
//   thread_mask    divergence mask, 1 = lane participates
//   fetcher_state  fetcher phase, 3'b010 = instruction fetched
//   lsu_state      2 bits per lane: 00 idle, 01 requesting, 10 waiting, 11 done
//   decoded_ret    current instruction is RET
//   core_state     registered phase code
//   done           block finished (normally or aborted)
//   timeout_error  block aborted by the WAIT watchdog (sticky until start)
//   retired_count  instructions completed since the last start (wraps)
module warp_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int RETIRED_BITS      = 16,
    parameter int WAIT_TIMEOUT      = 255
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
    input  logic [THREADS_PER_BLOCK-1:0]         thread_mask,
    input  logic [2:0]                           fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
    input  logic                                 decoded_ret,
    output logic [2:0]                           core_state,
    output logic                                 done,
    output logic                                 timeout_error,
    output logic [RETIRED_BITS-1:0]              retired_count
);

    localparam int TC_W   = $clog2(THREADS_PER_BLOCK) + 1;
    // Counter is wide enough to hold WAIT_TIMEOUT itself.
    localparam int WCNT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic [RETIRED_BITS-1:0] retired_q, retired_d;
    logic [WCNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [WCNT_W-1:0]       wait_cnt_inc;

    logic [THREADS_PER_BLOCK-1:0] lane_busy;
    logic                         any_busy;

    // A lane holds WAIT only if it is live, unmasked and its LSU is mid-flight.
    generate
        for (genvar gi = 0; gi < THREADS_PER_BLOCK; gi++) begin : g_lane
            localparam logic [TC_W-1:0] LANE_IDX = TC_W'(gi);
            logic [1:0] lane_lsu;
            assign lane_lsu      = lsu_state[2*gi+1 -: 2];
            assign lane_busy[gi] = (LANE_IDX < thread_count) && thread_mask[gi] &&
                                   ((lane_lsu == 2'b01) || (lane_lsu == 2'b10));
        end
    endgenerate

    assign any_busy     = |lane_busy;
    assign wait_cnt_inc = wait_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        timeout_d  = timeout_q;
        retired_d  = retired_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    retired_d = '0;
                    timeout_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (fetcher_state == 3'b010) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                // Completion is checked first so it wins over a simultaneous timeout.
                if (!any_busy) begin
                    state_d = S_EXECUTE;
                end else if ((WAIT_TIMEOUT != 0) && (wait_cnt_inc == WAIT_LIMIT)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                retired_d = retired_q + 1'b1;
                state_d   = decoded_ret ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            retired_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            retired_q  <= retired_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign core_state    = state_q;
    assign done          = done_q;
    assign timeout_error = timeout_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler: the driver pushes the expected phase,
// done, timeout and retired count for each cycle; a monitor pops and compares.
module tb_warp_scheduler;

    localparam int T  = 4;
    localparam int RB = 4;
    localparam int WT = 8;

    localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010,
                           S_REQUEST = 3'b011, S_WAIT = 3'b100, S_EXECUTE = 3'b101,
                           S_UPDATE = 3'b110, S_DONE = 3'b111;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    thread_count;
    logic [T-1:0]  thread_mask;
    logic [2:0]    fetcher_state;
    logic [2*T-1:0] lsu_state;
    logic          decoded_ret;
    logic [2:0]    core_state;
    logic          done;
    logic          timeout_error;
    logic [RB-1:0] retired_count;

    warp_scheduler #(
        .THREADS_PER_BLOCK(T),
        .RETIRED_BITS(RB),
        .WAIT_TIMEOUT(WT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .thread_count(thread_count),
        .thread_mask(thread_mask),
        .fetcher_state(fetcher_state),
        .lsu_state(lsu_state),
        .decoded_ret(decoded_ret),
        .core_state(core_state),
        .done(done),
        .timeout_error(timeout_error),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard queues
    logic [2:0]    q_state[$];
    logic          q_done[$];
    logic          q_to[$];
    logic [RB-1:0] q_ret[$];
    string         q_name[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [RB-1:0] exp_ret;
    logic          exp_to;
    event          mid_chk;

    task automatic push(input logic [2:0] s, input string nm);
        q_state.push_back(s);
        q_done.push_back(s == S_DONE);
        q_to.push_back(exp_to);
        q_ret.push_back(exp_ret);
        q_name.push_back(nm);
    endtask

    // Inputs already set by the caller apply to the coming edge.
    task automatic step(input logic [2:0] s, input string nm);
        @(posedge clk);
        #1;
        push(s, nm);
    endtask

    // Reset is raised mid-cycle, after the falling edge, and checked before
    // the next rising edge.
    task automatic do_reset(input string nm);
        @(negedge clk);
        #1;
        reset   = 1'b1;
        exp_ret = '0;
        exp_to  = 1'b0;
        #1;
        push(S_IDLE, nm);
        ->mid_chk;
        step(S_IDLE, "reset_hold");
        reset = 1'b0;
        step(S_IDLE, "idle");
    endtask

    task automatic do_start(input string nm);
        start   = 1'b1;
        exp_ret = '0;
        exp_to  = 1'b0;
        step(S_FETCH, nm);
        start = 1'b0;
    endtask

    // One instruction from a freshly entered FETCH. n_busy = WAIT cycles
    // during which busy_lsu is presented; afterwards idle_lsu.
    task automatic instr(input int fh, input int n_busy, input logic [2*T-1:0] busy_lsu,
                         input logic [2*T-1:0] idle_lsu, input bit ret, input bit rst_exec,
                         input string nm);
        fetcher_state = 3'b000;
        lsu_state     = idle_lsu;
        for (int i = 0; i < fh; i++) step(S_FETCH, nm);
        fetcher_state = 3'b010;
        step(S_DECODE, nm);
        fetcher_state = 3'b000;
        step(S_REQUEST, nm);
        step(S_WAIT, nm);
        for (int c = 1; c < 1000; c++) begin
            lsu_state = (c <= n_busy) ? busy_lsu : idle_lsu;
            if (c > n_busy) begin
                step(S_EXECUTE, nm);
                break;
            end
            if (c == WT) begin
                exp_to = 1'b1;
                step(S_DONE, {nm, "_abort"});
                lsu_state = idle_lsu;
                return;
            end
            step(S_WAIT, nm);
        end
        lsu_state = idle_lsu;
        if (rst_exec) begin
            do_reset({nm, "_async_reset"});
            return;
        end
        step(S_UPDATE, nm);
        decoded_ret = ret;
        exp_ret     = exp_ret + 1'b1;
        step(ret ? S_DONE : S_FETCH, nm);
        decoded_ret = 1'b0;
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk or mid_chk);
            if (q_state.size() > 0) begin
                logic [2:0]    es;
                logic          ed, et;
                logic [RB-1:0] er;
                string         en;
                es = q_state.pop_front();
                ed = q_done.pop_front();
                et = q_to.pop_front();
                er = q_ret.pop_front();
                en = q_name.pop_front();
                n_compared++;
                if (core_state !== es || done !== ed || timeout_error !== et ||
                    retired_count !== er) begin
                    n_mismatched++;
                    $display("FAIL %s: got state=%b done=%b to=%b ret=%0d, expected state=%b done=%b to=%b ret=%0d",
                             en, core_state, done, timeout_error, retired_count, es, ed, et, er);
                end else begin
                    $display("ok   %s: state=%b done=%b to=%b ret=%0d",
                             en, core_state, done, timeout_error, retired_count);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        thread_count  = 3'd4;
        thread_mask   = 4'b1111;
        fetcher_state = 3'b000;
        lsu_state     = '0;
        decoded_ret   = 1'b0;
        exp_ret       = '0;
        exp_to        = 1'b0;

        do_reset("reset");

        // Straight-line: three instructions, RET on the third
        do_start("start");
        instr(1, 0, 8'h00, 8'h00, 1'b0, 1'b0, "line1");
        instr(1, 0, 8'h00, 8'h00, 1'b0, 1'b0, "line2");
        instr(1, 0, 8'h00, 8'h00, 1'b1, 1'b0, "line3_ret");
        step(S_DONE, "done_hold");

        do_reset("reset2");
        do_start("start2");
        // Lane 2 waiting for 5 cycles then DONE (11): WAIT lasts 6 cycles
        instr(0, 5, 8'b00_10_00_00, 8'b00_11_00_00, 1'b0, 1'b0, "mem_wait");
        // Lane 2 masked, lane 3 inactive: both busy but ignored
        thread_mask  = 4'b1011;
        thread_count = 3'd2;
        instr(0, 0, 8'b10_10_00_00, 8'b10_10_00_00, 1'b0, 1'b0, "masked");
        // No live lanes at all
        thread_mask  = 4'b1111;
        thread_count = 3'd0;
        instr(0, 0, 8'b01_10_01_10, 8'b01_10_01_10, 1'b0, 1'b0, "tc_zero");
        thread_count = 3'd4;
        // Long fetch
        instr(3, 0, 8'h00, 8'h00, 1'b0, 1'b0, "fetch_hold");
        // Last busy lane clears on the very cycle the watchdog limit is reached
        instr(0, WT - 1, 8'b00_00_00_01, 8'h00, 1'b0, 1'b0, "wd_boundary");
        // Lane 0 stuck requesting: aborted after WT cycles in WAIT
        instr(0, 100, 8'b00_00_00_01, 8'h00, 1'b0, 1'b0, "watchdog");
        start = 1'b1;
        step(S_DONE, "abort_hold_start");
        start = 1'b0;

        do_reset("reset3");
        do_start("start_after_abort");
        instr(0, 0, 8'h00, 8'h00, 1'b0, 1'b0, "pre_async");
        instr(0, 0, 8'h00, 8'h00, 1'b0, 1'b1, "exec");
        do_start("start_after_async");

        // 17 instructions into a 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            instr(0, 0, 8'h00, 8'h00, (i == 16), 1'b0, "wrap");
        end
        start = 1'b1;
        for (int i = 0; i < 3; i++) step(S_DONE, "done_start_ignored");
        start = 1'b0;

        for (int i = 0; i < 10 && q_state.size() > 0; i++) @(negedge clk);
        if (q_state.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", q_state.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
